// File: rtl/repeated_add_multiplier_pkg.sv
// Shared definitions for the repeated-add multiplier: state encoding,
// datapath widths and the operand consistency helper.
package repeated_add_multiplier_pkg;

    localparam int OPERAND_W = 8;
    localparam int RESULT_W  = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // A remainder not smaller than the divisor means the operand triple is inconsistent.
    function automatic logic operands_inconsistent(
        input logic [OPERAND_W-1:0] r,
        input logic [OPERAND_W-1:0] d
    );
        return (r >= d);
    endfunction

endpackage

// File: rtl/repeated_add_multiplier_if.sv
// Request/result bundle of the repeated-add multiplier; the requester
// uses the master modport, the datapath block the slave modport.
interface repeated_add_multiplier_if;
    import repeated_add_multiplier_pkg::*;

    logic                 start;
    logic [OPERAND_W-1:0] din_Q;
    logic [OPERAND_W-1:0] din_D;
    logic [OPERAND_W-1:0] din_R;
    logic [RESULT_W-1:0]  dout_N;
    logic                 busy;
    logic                 done;
    logic                 err;

    modport master (
        output start, din_Q, din_D, din_R,
        input  dout_N, busy, done, err
    );

    modport slave (
        input  start, din_Q, din_D, din_R,
        output dout_N, busy, done, err
    );

endinterface

// File: rtl/repeated_add_multiplier_add_accumulator.sv
// Datapath of the repeated-add multiplier: holds the addend, the running
// sum and the remaining repeat count, advanced by load/step strobes.
module add_accumulator
    import repeated_add_multiplier_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [OPERAND_W-1:0] q_in,
    input  logic [OPERAND_W-1:0] d_in,
    input  logic [OPERAND_W-1:0] r_in,
    output logic [RESULT_W-1:0]  acc,
    output logic                 cnt_zero
);

    logic [OPERAND_W-1:0] d_r;
    logic [OPERAND_W-1:0] cnt_r;
    logic [RESULT_W-1:0]  acc_r;

    // Operand capture on load, one addition per step, otherwise hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_r   <= {OPERAND_W{1'b0}};
            cnt_r <= {OPERAND_W{1'b0}};
            acc_r <= {RESULT_W{1'b0}};
        end else if (load) begin
            d_r   <= d_in;
            cnt_r <= q_in;
            acc_r <= {{(RESULT_W-OPERAND_W){1'b0}}, r_in};
        end else if (step) begin
            d_r   <= d_r;
            cnt_r <= cnt_r - {{(OPERAND_W-1){1'b0}}, 1'b1};
            acc_r <= acc_r + {{(RESULT_W-OPERAND_W){1'b0}}, d_r};
        end else begin
            d_r   <= d_r;
            cnt_r <= cnt_r;
            acc_r <= acc_r;
        end
    end

    assign acc      = acc_r;
    assign cnt_zero = (cnt_r == {OPERAND_W{1'b0}});

endmodule

// File: rtl/repeated_add_multiplier.sv
// Reconstructs N = Q*D + R by adding D to R, Q times; the controller
// sequences IDLE -> RUN -> DONE and registers all visible outputs.
module repeated_add_multiplier
    import repeated_add_multiplier_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    repeated_add_multiplier_if.slave  bus
);

    logic [1:0]          state_r;
    logic [1:0]          state_nxt_s;
    logic                load_s;
    logic                step_s;
    logic                finish_s;
    logic                cnt_zero_s;
    logic [RESULT_W-1:0] acc_s;
    logic [RESULT_W-1:0] dout_n_r;
    logic                busy_r;
    logic                done_r;
    logic                err_r;

    add_accumulator u_add_accumulator (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .step     (step_s),
        .q_in     (bus.din_Q),
        .d_in     (bus.din_D),
        .r_in     (bus.din_R),
        .acc      (acc_s),
        .cnt_zero (cnt_zero_s)
    );

    // Start is only honoured in IDLE, so requests during RUN/DONE are dropped.
    always_comb begin
        load_s   = (state_r == ST_IDLE) && bus.start;
        step_s   = (state_r == ST_RUN) && !cnt_zero_s;
        finish_s = (state_r == ST_RUN) && cnt_zero_s;
    end

    // Next-state logic of the three-state controller.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_zero_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Controller state and registered status/result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            dout_n_r <= {RESULT_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            done_r  <= finish_s;
            if (load_s) begin
                busy_r <= 1'b1;
                err_r  <= operands_inconsistent(bus.din_R, bus.din_D);
            end else if (finish_s) begin
                busy_r   <= 1'b0;
                dout_n_r <= acc_s;
            end else begin
                busy_r   <= busy_r;
                err_r    <= err_r;
                dout_n_r <= dout_n_r;
            end
        end
    end

    assign bus.dout_N = dout_n_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.err    = err_r;

endmodule

// File: tb/tb_repeated_add_multiplier.sv
// Directed bench for repeated_add_multiplier; expected results are hand-computed.
module tb_repeated_add_multiplier;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    repeated_add_multiplier_if bus ();

    repeated_add_multiplier dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // mode 0: plain pulse; 1: re-pulse start and change operands mid-RUN; 2: keep start high.
    task automatic run_op(input string tag, input logic [7:0] q, input logic [7:0] d,
                          input logic [7:0] r, input logic [15:0] exp_n,
                          input logic exp_err, input int mode);
        int          n;
        bit          seen;
        bit          held;
        logic [15:0] prev_n;
        prev_n    = bus.dout_N;
        held      = 1'b1;
        seen      = 1'b0;
        bus.din_Q = q;
        bus.din_D = d;
        bus.din_R = r;
        bus.start = 1'b1;
        tick();
        n = 1;
        if (mode != 2) bus.start = 1'b0;
        check({tag, "_busy_after_load"}, bus.busy, 32'd1);
        while (!seen && n < 600) begin
            if (bus.done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (bus.dout_N !== prev_n) held = 1'b0;
                if (mode == 1 && n == 3) begin
                    bus.start = 1'b1;
                    bus.din_Q = 8'd50;
                    bus.din_D = 8'd99;
                    bus.din_R = 8'd77;
                end
                if (mode == 1 && n == 6) bus.start = 1'b0;
                tick();
                n++;
            end
        end
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        check({tag, "_latency"}, n, {24'd0, q} + 32'd2);
        check({tag, "_dout_N"}, {16'd0, bus.dout_N}, {16'd0, exp_n});
        check({tag, "_err"}, {31'd0, bus.err}, {31'd0, exp_err});
        check({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_dout_held_in_run"}, {31'd0, held}, 32'd1);
        tick();
        check({tag, "_done_single_pulse"}, {31'd0, bus.done}, 32'd0);
        check({tag, "_idle_after_done"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        bit done_seen;
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.din_Q = 8'd0;
        bus.din_D = 8'd0;
        bus.din_R = 8'd0;
        #1;
        check("reset_dout_N", {16'd0, bus.dout_N}, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_err", {31'd0, bus.err}, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("idle_hold_busy", {31'd0, bus.busy}, 32'd0);

        run_op("q5_d7_r3", 8'd5, 8'd7, 8'd3, 16'd38, 1'b0, 0);
        run_op("q255_d255_r254", 8'd255, 8'd255, 8'd254, 16'd65279, 1'b0, 0);
        run_op("q0_d9_r4", 8'd0, 8'd9, 8'd4, 16'd4, 1'b0, 0);
        run_op("q3_d0_r2", 8'd3, 8'd0, 8'd2, 16'd2, 1'b1, 0);
        run_op("q10_d3_r1_disturbed", 8'd10, 8'd3, 8'd1, 16'd31, 1'b0, 1);
        tick();
        check("no_queued_start_busy", {31'd0, bus.busy}, 32'd0);
        check("no_queued_start_dout", {16'd0, bus.dout_N}, 32'd31);

        // Abort a long operation with reset after six RUN cycles.
        bus.din_Q = 8'd20;
        bus.din_D = 8'd5;
        bus.din_R = 8'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (6) tick();
        rst = 1'b0;
        #1;
        check("midrun_reset_dout_N", {16'd0, bus.dout_N}, 32'd0);
        check("midrun_reset_busy", {31'd0, bus.busy}, 32'd0);
        check("midrun_reset_done", {31'd0, bus.done}, 32'd0);
        check("midrun_reset_err", {31'd0, bus.err}, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) done_seen = 1'b1;
        end
        check("aborted_op_silent", {31'd0, done_seen}, 32'd0);
        run_op("q2_d4_r1_after_reset", 8'd2, 8'd4, 8'd1, 16'd9, 1'b0, 0);

        // Start held high across completion: it must not be taken while in DONE.
        run_op("q4_d6_r6_held_start", 8'd4, 8'd6, 8'd6, 16'd30, 1'b1, 2);
        check("held_start_err_kept", {31'd0, bus.err}, 32'd1);
        check("held_start_dout_kept", {16'd0, bus.dout_N}, 32'd30);
        run_op("q1_d2_r1_second", 8'd1, 8'd2, 8'd1, 16'd3, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/repeated_add_multiplier.md
REPEATED_ADD_MULTIPLIER -- requirements
Module: repeated_add_multiplier

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; all other ports are listed below.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 din_Q  input  8  quotient operand (repeat count).
REQ-006 din_D  input  8  divisor operand (addend).
REQ-007 din_R  input  8  remainder operand (initial accumulator).
REQ-008 dout_N  output  16  reconstructed dividend N = Q*D + R.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse; result valid.
REQ-011 err  output  1  operands inconsistent (R >= D); valid with done, held until the next load.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 IDLE with start=1 at an edge: latch D, set acc = zero-extended R, set cnt = Q, set err = (R >= D), go to RUN; busy SHALL be 1 from that edge.
REQ-014 IDLE with start=0: hold all registers and outputs.
REQ-015 RUN with cnt != 0 at an edge: acc <= acc + D (16-bit), cnt <= cnt - 1.
REQ-016 RUN with cnt == 0 at an edge: dout_N <= acc, done <= 1, busy <= 0, go to DONE.
REQ-017 DONE: unconditionally return to IDLE at the next edge, and clear done (single-cycle pulse).
REQ-018 Latency: done SHALL rise exactly Q+2 edges after the edge that samples start.
REQ-019 Any start asserted in RUN or DONE SHALL be ignored; no queueing.
REQ-020 A start in the same cycle that DONE returns to IDLE SHALL be ignored; only start sampled while in IDLE is accepted.
REQ-021 The operand inputs SHALL be sampled only at the load edge; later changes SHALL not affect the result.
REQ-022 Addition SHALL be unsigned 16-bit with no overflow, since the maximum result 255*255+255 = 65280 fits in 16 bits.
REQ-023 Q=0: result = R, with done two edges after start.
REQ-024 D=0: result = R after Q idle additions; err = 1.
REQ-025 dout_N SHALL hold the last result until the next DONE, and SHALL not change during RUN.

Reset
REQ-026 When rst=0, the block SHALL asynchronously force state=IDLE, acc=0, cnt=0, dout_N=0, busy=0, done=0 and err=0.
REQ-027 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after rst returns to 1 SHALL be processed normally.

Structure
REQ-028 A shared package SHALL hold: state encoding (IDLE, RUN, DONE), the operand width constant (8) and the result width constant (16).
REQ-029 The block SHALL split into controller FSM plus one sub-module add_accumulator, containing the acc/cnt/D registers, adder, and cnt==0 flag, driven by load/step control lines.

Verification
REQ-030 Q=5, D=7, R=3, start pulse -> done 7 edges later, dout_N=38, err=0.
REQ-031 Q=255, D=255, R=254 -> dout_N=65279, done at edge 257, err=0; no overflow.
REQ-032 Q=0, D=9, R=4 -> dout_N=4 after 2 edges; then Q=3, D=0, R=2 -> dout_N=2, err=1.
REQ-033 Q=10, D=3, R=1: start re-pulsed and operands changed during RUN -> ignored, dout_N=31, single done pulse.
REQ-034 Q=20, D=5, R=0: rst low at RUN cycle 6 -> all outputs 0, no done; start with Q=2, D=4, R=1 -> dout_N=9.
REQ-035 Q=4, D=6, R=6 -> dout_N=30, err=1; back-to-back start held high -> second operation begins only after return to IDLE.
